// File: rtl/vga_data_writer.sv
//==============================================================================
// Module : vga_data_writer
// Brief  : Valid/ready byte-stream loader that writes a fixed-length burst into
//          a byte RAM, with a registered synchronous read port for the VGA side.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_data_writer #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int DATA_W = 8,
    parameter int LEN    = 76,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [AW:0]       wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_base     = AW'(BASE);
    localparam logic [AW:0]   c_last_idx = (AW+1)'(LEN - 1);
    localparam logic [AW-1:0] c_addr_one = AW'(1);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);

    state_t              r_state;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic [AW-1:0]       r_addr;
    logic [AW:0]         r_count;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_last;
    logic [DATA_W-1:0]   w_wdata;

    // in_ready is exactly "in FILL", so accept never depends combinationally on itself
    assign w_accept = r_in_ready & in_valid;
    assign w_last   = w_accept && (r_count == c_last_idx);

`ifdef SYNTHESIS
    assign w_wdata = in_data;
`else
    assign w_wdata = $isunknown(in_data) ? '0 : in_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_count    <= '0;
            r_addr     <= c_base;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FILL;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_addr     <= c_base;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_addr  <= r_addr + c_addr_one;
                        r_count <= r_count + c_cnt_one;
                    end
                    // abort outranks completion of the final byte
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_aborted  <= 1'b1;
                    end else if (w_last) begin
                        r_state    <= ST_FINISH;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_mem[r_addr] <= w_wdata;
        end
    end

    // Read-before-write: a same-address write lands after this read samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign wr_count = r_count;
    assign rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_vga_data_writer.sv
//==============================================================================
// Module : tb_vga_data_writer
// Brief  : Randomised and directed bench for vga_data_writer against a
//          behavioural burst/memory model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_data_writer;

    localparam int DEPTH = 1024;
    localparam int LEN   = 76;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [9:0]  rd_addr = 10'd0;
    logic        in_ready, busy, done, aborted;
    logic [7:0]  rd_data;
    logic [10:0] wr_count;

    logic        start2 = 1'b0, valid2 = 1'b0;
    logic [7:0]  data2 = 8'h00;
    logic [9:0]  rd_addr2 = 10'd0;
    logic        in_ready2, busy2, done2, aborted2;
    logic [7:0]  rd_data2;
    logic [10:0] wr_count2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_data_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .aborted(aborted), .wr_count(wr_count)
    );

    vga_data_writer #(.BASE(1020), .LEN(8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .in_valid(valid2), .in_data(data2), .in_ready(in_ready2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2),
        .aborted(aborted2), .wr_count(wr_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: burst phase (0 idle, 1 filling, 2 finishing) plus a byte array
    logic [7:0] m_mem [DEPTH];
    bit         m_written [DEPTH];
    int         m_phase = 0, m_count = 0, m_addr = 0;
    bit         m_done = 0, m_ab = 0, m_rd_known = 0, model_ok = 0;
    logic [7:0] m_rd = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_count = 0; m_addr = 0;
            m_done = 0; m_ab = 0; m_rd = 8'h00; m_rd_known = 1; model_ok = 1;
        end else if (model_ok) begin
            m_rd = m_mem[rd_addr];
            m_rd_known = m_written[rd_addr];
            m_done = 0; m_ab = 0;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_count = 0; m_addr = 0; end
                1: begin
                    if (in_valid) begin
                        m_mem[m_addr] = in_data;
                        m_written[m_addr] = 1;
                        m_addr = (m_addr + 1) % DEPTH;
                        m_count++;
                    end
                    if (abort) begin m_phase = 0; m_ab = 1; end
                    else if (m_count == LEN) begin m_phase = 2; m_done = 1; end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", in_ready, m_phase == 1);
            chk("busy", busy, m_phase == 1);
            chk("done", done, m_done);
            chk("aborted", aborted, m_ab);
            chk("wr_count", wr_count, m_count);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
        end
    end

    logic [7:0] last_sent [LEN];
    logic [7:0] rd_hist [1024];

    // vmode: 0 continuous, 1 alternate valid, 2 random valid; drand selects random data
    task automatic send(input int n, input int vmode, input logic [7:0] dbase,
                        input bit drand, input bit hold_rd, output int cyc);
        int acc = 0;
        cyc = 0;
        while (acc < n && cyc < 1000) begin
            @(posedge clk); #1;
            rd_hist[cyc] = rd_data;
            start = 1'b0; abort = 1'b0;
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            in_data  = drand ? 8'($urandom) : 8'(dbase + 8'(acc));
            if (!hold_rd) rd_addr = 10'($urandom_range(0, 127));
            if (in_valid && in_ready) begin
                last_sent[acc] = in_data;
                acc++;
            end
            cyc++;
        end
        if (acc < n) chk("send_timeout", acc, n);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] old3;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_wr_count", wr_count, 11'd0);
        chk("reset_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;

        // Wrapping instance: 8 bytes from 1020 land at 1020..1023 then 0..3
        @(posedge clk); #1; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid2 = 1'b1; data2 = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        valid2 = 1'b0;
        chk("wrap_done", done2, 1'b1);
        chk("wrap_count", wr_count2, 11'd8);
        for (int i = 0; i < 8; i++) begin
            rd_addr2 = 10'((1020 + i) % DEPTH);
            @(posedge clk); #1;
            chk("wrap_rd", rd_data2, 8'hA0 + 8'(i));
        end

        // Continuous fill 0x00..0x4B
        pulse_start();
        send(LEN, 0, 8'h00, 0, 0, cyc);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("t1_done", done, 1'b1);
        chk("t1_count", wr_count, 11'd76);
        rd_addr = 10'd5;
        @(posedge clk); #1;
        chk("t1_rd5", rd_data, 8'h05);
        chk("t1_done_once", done, 1'b0);

        // Throttled fill: valid on alternate cycles
        pulse_start();
        send(LEN, 1, 8'h40, 0, 0, cyc);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("t2_done", done, 1'b1);
        chk("t2_cycles", cyc, 151);
        rd_addr = 10'd75;
        @(posedge clk); #1;
        chk("t2_rd75", rd_data, 8'h40 + 8'd75);

        // Abort after 10 bytes with an 11th byte in the abort cycle
        pulse_start();
        send(10, 0, 8'h10, 0, 0, cyc);
        @(posedge clk); #1;
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0; rd_addr = 10'd10;
        chk("t3_aborted", aborted, 1'b1);
        chk("t3_done", done, 1'b0);
        chk("t3_count", wr_count, 11'd11);
        @(posedge clk); #1;
        chk("t3_rd10", rd_data, 8'h5A);
        chk("t3_aborted_once", aborted, 1'b0);
        pulse_start();
        send(LEN, 2, 8'h00, 1, 0, cyc);
        old3 = last_sent[3];
        @(posedge clk); #1; in_valid = 1'b0;

        // Same-address read and write at address 3
        rd_addr = 10'd3;
        pulse_start();
        send(LEN, 0, 8'hC0, 0, 1, cyc);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("t4_old", rd_hist[4], old3);
        chk("t4_new", rd_hist[5], 8'hC3);

        // Mid-burst reset after 20 bytes
        pulse_start();
        send(20, 0, 8'h20, 0, 0, cyc);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
        @(posedge clk); #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", in_ready, 1'b0);
        chk("t5_count", wr_count, 11'd0);
        chk("t5_rd", rd_data, 8'h00);
        rst_n = 1'b1; in_valid = 1'b0; rd_addr = 10'd19;
        @(posedge clk); #1;
        chk("t5_rd19", rd_data, 8'h33);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_restart_count", wr_count, 11'd0);
        chk("t5_restart_ready", in_ready, 1'b1);
        send(LEN, 2, 8'h00, 1, 0, cyc);
        @(posedge clk); #1; in_valid = 1'b0;

        // Free-running random traffic
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(0, 15) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            rd_addr  = 10'($urandom_range(0, 127));
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
